alu_issue_ctrl: RTL and testbench
=================================

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4, command FIFO entries (power of two, >= 2).
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port cmd_valid  input  1  command offered.
REQ-005 SHALL have port cmd_ready  output  1  command FIFO can accept.
REQ-006 SHALL have ports cmd_op  input  3, cmd_a  input  8, cmd_b  input  8  (ALU opcode and operands).
REQ-007 SHALL have port cmd_acc  input  1  use accumulator in place of cmd_a.
REQ-008 SHALL have ports alu_op  output  3, alu_a  output  8, alu_b  output  8  (drive external combinational ALU).
REQ-009 SHALL have ports alu_result  input  8, alu_carry  input  1  (from external ALU).
REQ-010 SHALL have ports rsp_valid  output  1, rsp_ready  input  1  (response handshake).
REQ-011 SHALL have ports rsp_result  output  8, rsp_carry  output  1, rsp_zero  output  1  (response data).
REQ-012 SHALL have port busy  output  1  high when state != IDLE or FIFO non-empty.
REQ-013 SHALL have port count  output  $clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-014 SHALL push on cmd_valid && cmd_ready; cmd_ready = (count < DEPTH), independent of same-cycle pop.
REQ-015 SHALL store {cmd_op, cmd_acc, cmd_a, cmd_b} per entry; FIFO pointers wrap modulo DEPTH.
REQ-016 SHALL implement FSM states IDLE, ISSUE, RESP.
REQ-017 IDLE: if count != 0, pop head, register into alu_op/alu_a/alu_b, go ISSUE; else stay.
REQ-018 ISSUE: capture alu_result into rsp_result, alu_carry into rsp_carry, set rsp_zero = (alu_result == 0), set rsp_valid, go RESP.
REQ-019 RESP: hold rsp_* stable while rsp_valid && !rsp_ready; on rsp_valid && rsp_ready clear rsp_valid, go IDLE.
REQ-020 Simultaneous push and pop in IDLE SHALL leave count unchanged.
REQ-021 alu_op/alu_a/alu_b SHALL hold their values from the IDLE load until the next load.
REQ-022 Latency: command pushed into empty FIFO in idle block at edge N SHALL give rsp_valid high after edge N+2; minimum 3 cycles per command.
REQ-023 rsp_carry SHALL pass alu_carry unmodified for every opcode (no interpretation of opcode).
REQ-024 Accumulator register acc SHALL load rsp_result on each rsp handshake.

Reset
REQ-025 rst_n low SHALL asynchronously force: state IDLE, FIFO empty (count 0, pointers 0), cmd_ready 1 after release, rsp_valid 0, rsp_result 0, rsp_carry 0, rsp_zero 0, alu_op/alu_a/alu_b 0, acc 0, busy 0.
REQ-026 Reset mid-operation SHALL discard all queued and in-flight commands; no response issued for them.

Configuration
REQ-027 Macro ALU_ISSUE_ACC_FWD_EN defined: at IDLE load, alu_a = acc when entry cmd_acc = 1, else cmd_a.
REQ-028 Macro ALU_ISSUE_ACC_FWD_EN undefined: cmd_acc ignored (not stored), alu_a = cmd_a always, acc register absent.

Verification (bench connects a behavioural 8-bit ALU: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 not a, 110 shl, 111 shr; carry only for add/sub)
REQ-029 Push op=000 a=0xF0 b=0x20, rsp_ready=1 -> rsp_valid 2 cycles after push, rsp_result 0x10, rsp_carry 1, rsp_zero 0.
REQ-030 Push op=001 a=0x05 b=0x05 -> rsp_result 0x00, rsp_carry 0, rsp_zero 1; then op=101 a=0x0F -> 0xF0, carry 0.
REQ-031 rsp_ready=0, push 6 commands back-to-back -> 5 accepted (1 popped + 4 queued), cmd_ready 0 on 6th, count 4; release rsp_ready -> 5 responses in push order, none lost or duplicated.
REQ-032 Macro defined: op=000 a=0x05 b=0x03 -> 0x08; then op=000 acc=1 a=0xFF b=0x01 -> 0x09 carry 0; macro undefined same sequence -> 0x08 then 0x00 carry 1.
REQ-033 rsp_valid held with rsp_ready=0 for 10 cycles -> rsp_result/carry/zero stable; randomise rsp_ready -> every response delivered exactly once.
REQ-034 Assert rst_n low during RESP with 3 queued -> immediately rsp_valid 0, count 0, busy 0; after release no stale response emitted, new command processes normally.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
//------------------------------------------------------------------------------
// Module  : alu_issue_ctrl
// Brief   : Command FIFO feeding an external ALU, with a registered response
//           handshake. Optional feature macro: ALU_ISSUE_ACC_FWD_EN (accumulator
//           forwarding into operand A).
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module alu_issue_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [2:0]               cmd_op,
  input  logic [7:0]               cmd_a,
  input  logic [7:0]               cmd_b,
  input  logic                     cmd_acc,
  output logic [2:0]               alu_op,
  output logic [7:0]               alu_a,
  output logic [7:0]               alu_b,
  input  logic [7:0]               alu_result,
  input  logic                     alu_carry,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [7:0]               rsp_result,
  output logic                     rsp_carry,
  output logic                     rsp_zero,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = c_AW + 1;
`ifdef ALU_ISSUE_ACC_FWD_EN
  localparam int c_EW = 3 + 1 + 8 + 8;
`else
  localparam int c_EW = 3 + 8 + 8;
`endif
  localparam logic [c_CW-1:0] c_DEPTH = c_CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [c_EW-1:0]   r_mem [DEPTH];
  logic [c_AW-1:0]   r_wr_ptr;
  logic [c_AW-1:0]   r_rd_ptr;
  logic [c_CW-1:0]   r_count;
  logic [c_EW-1:0]   w_wdata;
  logic [c_EW-1:0]   w_entry;
  logic [2:0]        w_e_op;
  logic [7:0]        w_e_a;
  logic [7:0]        w_e_b;
  logic [7:0]        w_alu_a_nxt;
  logic              w_push;
  logic              w_pop;
  logic              w_rsp_hs;

  assign cmd_ready = (r_count < c_DEPTH);
  assign w_push    = cmd_valid && cmd_ready;
  assign w_pop     = (r_state == ST_IDLE) && (r_count != '0);
  assign w_rsp_hs  = (r_state == ST_RESP) && rsp_valid && rsp_ready;
  assign count     = r_count;
  assign busy      = (r_state != ST_IDLE) || (r_count != '0);

  assign w_entry = r_mem[r_rd_ptr];
  assign w_e_op  = w_entry[c_EW-1 -: 3];
  assign w_e_a   = w_entry[15:8];
  assign w_e_b   = w_entry[7:0];

`ifdef ALU_ISSUE_ACC_FWD_EN
  logic [7:0] r_acc;
  logic       w_e_acc;

  assign w_wdata     = {cmd_op, cmd_acc, cmd_a, cmd_b};
  assign w_e_acc     = w_entry[16];
  assign w_alu_a_nxt = w_e_acc ? r_acc : w_e_a;

  // Accumulator tracks the last response actually consumed downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= 8'h00;
    end else if (w_rsp_hs) begin
      r_acc <= rsp_result;
    end
  end
`else
  logic w_unused_acc;

  assign w_unused_acc = cmd_acc;
  assign w_wdata      = {cmd_op, cmd_a, cmd_b};
  assign w_alu_a_nxt  = w_e_a;
`endif

  // Storage is not reset; validity is tracked entirely by r_count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CW'(1);
        2'b01:   r_count <= r_count - c_CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (r_count != '0) w_state_nxt = ST_ISSUE;
      ST_ISSUE: w_state_nxt = ST_RESP;
      ST_RESP:  if (rsp_valid && rsp_ready) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // ALU operands stay put between loads; the external ALU is purely combinational.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_op     <= 3'd0;
      alu_a      <= 8'h00;
      alu_b      <= 8'h00;
      rsp_valid  <= 1'b0;
      rsp_result <= 8'h00;
      rsp_carry  <= 1'b0;
      rsp_zero   <= 1'b0;
    end else begin
      if (w_pop) begin
        alu_op <= w_e_op;
        alu_a  <= w_alu_a_nxt;
        alu_b  <= w_e_b;
      end
      if (r_state == ST_ISSUE) begin
        rsp_result <= alu_result;
        rsp_carry  <= alu_carry;
        rsp_zero   <= (alu_result == 8'h00);
        rsp_valid  <= 1'b1;
      end else if (w_rsp_hs) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
//------------------------------------------------------------------------------
// Module  : tb_alu_issue_ctrl
// Brief   : Scoreboard bench for alu_issue_ctrl with a behavioural ALU and
//           reference model. Honours ALU_ISSUE_ACC_FWD_EN.
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_alu_issue_ctrl;

  localparam int DEPTH = 4;
`ifdef ALU_ISSUE_ACC_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = 3'd0;
  logic [7:0] cmd_a = 8'h00;
  logic [7:0] cmd_b = 8'h00;
  logic       cmd_acc = 1'b0;
  logic [2:0] alu_op;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [7:0] alu_result;
  logic       alu_carry;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_result;
  logic       rsp_carry;
  logic       rsp_zero;
  logic       busy;
  logic [$clog2(DEPTH):0] count;

  alu_issue_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_acc(cmd_acc),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
    .busy(busy), .count(count)
  );

  always #5 clk = ~clk;

  // Returns {carry, result}; carry is meaningful for add/sub only.
  function automatic logic [8:0] alu_ref9(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0:    return {1'b0, a} + {1'b0, b};
      3'd1:    return {1'b0, a} - {1'b0, b};
      3'd2:    return {1'b0, a & b};
      3'd3:    return {1'b0, a | b};
      3'd4:    return {1'b0, a ^ b};
      3'd5:    return {1'b0, ~a};
      3'd6:    return {1'b0, a << 1};
      default: return {1'b0, a >> 1};
    endcase
  endfunction

  always_comb {alu_carry, alu_result} = alu_ref9(alu_op, alu_a, alu_b);

  typedef struct packed {
    logic [7:0] res;
    logic       c;
    logic       z;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] model_acc = 8'h00;
  int         n_checks = 0;
  int         n_pass = 0;
  int         n_rsp = 0;
  int         n_pushed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Responses emerge in push order, so the accumulator seen by a command is the
  // result of the command pushed just before it.
  function automatic void model_push(input logic [2:0] op, input logic [7:0] a,
                                     input logic [7:0] b, input logic acc);
    logic [7:0] ae;
    logic [8:0] r;
    exp_t       e;
    ae = (FWD && acc) ? model_acc : a;
    r  = alu_ref9(op, ae, b);
    e.res = r[7:0];
    e.c   = r[8];
    e.z   = (r[7:0] == 8'h00);
    exp_q.push_back(e);
    model_acc = r[7:0];
    n_pushed++;
  endfunction

  task automatic push(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic acc);
    bit ok;
    ok = 0;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_acc = acc; cmd_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        model_push(op, a, b, acc);
        ok = 1;
      end
      @(posedge clk); #1;
      if (ok) break;
    end
    cmd_valid = 1'b0;
    if (!ok) chk("push_timeout", 0, 1);
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic run_one(input string name, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic acc, input logic [7:0] er, input logic ec, input logic ez);
    bit ok;
    push(op, a, b, acc);
    wait_rsp(ok);
    chk({name, "_valid"}, ok, 1);
    if (ok) begin
      chk({name, "_result"}, rsp_result, er);
      chk({name, "_carry"}, rsp_carry, ec);
      chk({name, "_zero"}, rsp_zero, ez);
    end
    @(posedge clk); #1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 400; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    chk(name, exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Monitor: scores every handshake and checks response stability under stall.
  initial begin
    bit         held;
    logic [7:0] h_res;
    logic       h_c, h_z;
    exp_t       e;
    held = 0; h_res = '0; h_c = 0; h_z = 0;
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid) begin
        if (rsp_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_rsp: got %0h expected no response", rsp_result);
          end else begin
            e = exp_q.pop_front();
            chk("rsp_result", rsp_result, e.res);
            chk("rsp_carry", rsp_carry, e.c);
            chk("rsp_zero", rsp_zero, e.z);
            n_rsp++;
          end
          held = 0;
        end else begin
          if (held) begin
            chk("stall_result", rsp_result, h_res);
            chk("stall_carry", rsp_carry, h_c);
            chk("stall_zero", rsp_zero, h_z);
          end
          held = 1; h_res = rsp_result; h_c = rsp_carry; h_z = rsp_zero;
        end
      end else begin
        held = 0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int  accepted;
    bit  last_rdy;
    bit  ok;
    int  n0;
    logic [2:0] op;
    logic [7:0] a, b;
    logic       ac;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_carry", rsp_carry, 0);
    chk("rst_rsp_zero", rsp_zero, 0);
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    @(posedge clk); #1;

    // Latency into an idle, empty block: valid after the second edge past the push.
    rsp_ready = 1'b1;
    push(3'd0, 8'hF0, 8'h20, 1'b0);
    @(negedge clk);
    chk("lat_e0_valid", rsp_valid, 0);
    chk("lat_e0_busy", busy, 1);
    @(negedge clk);
    chk("lat_e1_valid", rsp_valid, 0);
    @(negedge clk);
    chk("lat_e2_valid", rsp_valid, 1);
    chk("lat_result", rsp_result, 8'h10);
    chk("lat_carry", rsp_carry, 1);
    chk("lat_zero", rsp_zero, 0);
    @(posedge clk); #1;

    run_one("sub_zero", 3'd1, 8'h05, 8'h05, 1'b0, 8'h00, 1'b0, 1'b1);
    run_one("not_a", 3'd5, 8'h0F, 8'h00, 1'b0, 8'hF0, 1'b0, 1'b0);
    run_one("acc_seed", 3'd0, 8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0);
`ifdef ALU_ISSUE_ACC_FWD_EN
    run_one("acc_fwd", 3'd0, 8'hFF, 8'h01, 1'b1, 8'h09, 1'b0, 1'b0);
`else
    run_one("acc_fwd", 3'd0, 8'hFF, 8'h01, 1'b1, 8'h00, 1'b1, 1'b1);
`endif

    // Back-pressure fill: one command goes in flight, DEPTH more queue up.
    rsp_ready = 1'b0;
    accepted = 0;
    last_rdy = 1'b1;
    cmd_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cmd_op = 3'($urandom); cmd_a = 8'($urandom); cmd_b = 8'($urandom); cmd_acc = 1'($urandom);
      @(negedge clk);
      last_rdy = cmd_ready;
      if (cmd_ready) begin
        model_push(cmd_op, cmd_a, cmd_b, cmd_acc);
        accepted++;
      end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    chk("fill_accepted", accepted, 5);
    chk("fill_ready6", last_rdy, 0);
    chk("fill_count", count, 4);
    chk("fill_busy", busy, 1);
    repeat (10) @(posedge clk);
    #1;
    n0 = n_rsp;
    rsp_ready = 1'b1;
    drain("fill_drain");
    chk("fill_rsp_count", n_rsp - n0, 5);

    // Random traffic against a randomly stalling consumer.
    fork
      begin
        for (int k = 0; k < 30; k++) begin
          op = 3'($urandom); a = 8'($urandom); b = 8'($urandom); ac = 1'($urandom);
          push(op, a, b, ac);
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
        end
      end
      begin
        for (int c = 0; c < 500; c++) begin
          @(posedge clk); #1;
          rsp_ready = 1'($urandom);
        end
        rsp_ready = 1'b1;
      end
    join
    drain("rand_drain");
    chk("rand_all_delivered", n_rsp, n_pushed);

    // Reset while a response is pending and commands are queued.
    rsp_ready = 1'b0;
    for (int k = 0; k < 4; k++) push(3'd4, 8'($urandom), 8'($urandom), 1'b0);
    wait_rsp(ok);
    chk("mid_rst_pending", ok, 1);
    chk("mid_rst_count_pre", count, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_busy", busy, 0);
    n_pushed = n_pushed - exp_q.size();
    exp_q.delete();
    model_acc = 8'h00;
    @(posedge clk); #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    n0 = n_rsp;
    repeat (10) @(negedge clk);
    chk("post_rst_no_stale", n_rsp, n0);
    chk("post_rst_busy", busy, 0);
    @(posedge clk); #1;
    run_one("post_rst_cmd", 3'd0, 8'h11, 8'h22, 1'b0, 8'h33, 1'b0, 1'b0);
    drain("final_drain");
    chk("final_delivered", n_rsp, n_pushed);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
